// File: rtl/addsub_share_arb.sv
// Round-robin arbiter/sequencer time-sharing one registered WIDTH-bit add/sub unit among N requesters.
// Define ADDSUB_SHARE_ARB_PRIO0_EN to give requester 0 fixed highest priority.
module addsub_share_arb #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned N     = 4,
  parameter int unsigned IDW   = 2,
  parameter int unsigned LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N-1:0]       req_sub,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       req_ready,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH:0]     add_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [WIDTH:0]     rsp_data,
  output logic               busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant, hi_idx, lo_idx;
  logic [N-1:0]   rr_valid;
  logic           any_hi, any_lo, upd_ptr, xfer;

  logic [LAT-1:0] vld_q;
  logic [IDW-1:0] id_q [LAT];

  // Two-pass search: first valid at or above ptr, else first valid overall (wrap).
  always_comb begin
    rr_valid = req_valid;
`ifdef ADDSUB_SHARE_ARB_PRIO0_EN
    rr_valid[0] = 1'b0;
`endif
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rr_valid[i] && !any_lo) begin
        any_lo = 1'b1;
        lo_idx = IDW'(i);
      end
      if (rr_valid[i] && !any_hi && (IDW'(i) >= ptr_q)) begin
        any_hi = 1'b1;
        hi_idx = IDW'(i);
      end
    end
    grant   = any_hi ? hi_idx : lo_idx;
    upd_ptr = any_lo;
`ifdef ADDSUB_SHARE_ARB_PRIO0_EN
    // Requester 0 wins outright and leaves the round-robin pointer untouched.
    if (req_valid[0]) begin
      grant   = '0;
      upd_ptr = 1'b0;
    end
`endif
  end

  assign xfer = (|req_valid) & ~rst;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && upd_ptr) begin
      ptr_d = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (xfer && (grant == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[i*WIDTH +: WIDTH];
        add_b        = req_b[i*WIDTH +: WIDTH];
        add_cin      = req_sub[i];
      end
    end
  end

  // Tag pipeline tracks the adder latency; ids only advance with a valid so rsp_id holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= xfer;
      if (xfer) begin
        id_q[0] <= grant;
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          id_q[k] <= id_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign rsp_data  = add_out;
  assign busy      = (|vld_q) | (|req_valid);

endmodule
